// File: rtl/event_pkt_pkg.sv
// Shared types and helpers for the event packetizer.
package event_pkt_pkg;

    // Default start-of-frame marker
    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StSof,
        StSeq,
        StPayload,
        StChk
    } pkt_state_e;

    // Number of whole bytes needed to carry a w-bit event
    function automatic int evt_bytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/event_packetizer.sv
// Pops captured events from the monitor FIFO and serializes each one into a
// framed byte stream: SOF, sequence number, payload MSB-first, XOR checksum.
module event_packetizer
    import event_pkt_pkg::*;
#(
    parameter int unsigned PROBE_W  = 32,
    parameter int unsigned ID_W     = 8,
    parameter int unsigned TS_W     = 32,
    parameter logic [7:0]  SOF_BYTE = SOF_BYTE_DEFAULT
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_evt_valid,
    input  logic [TS_W+ID_W+PROBE_W-1:0]  i_evt_data,
    output logic                          o_evt_pop,
    output logic                          o_out_valid,
    output logic [7:0]                    o_out_data,
    output logic                          o_out_last,
    input  logic                          i_out_ready,
    output logic                          o_busy,
    output logic [7:0]                    o_seq,
    output logic [15:0]                   o_frames_sent
);

    localparam int unsigned EVT_W     = TS_W + ID_W + PROBE_W;
    localparam int unsigned EVT_BYTES = int'(evt_bytes(int'(EVT_W)));
    localparam int unsigned SR_W      = EVT_BYTES * 8;
    localparam int unsigned IDX_W     = (EVT_BYTES > 1) ? $clog2(EVT_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EVT_BYTES - 1);

    pkt_state_e        r_state;
    pkt_state_e        w_state_next;
    logic [SR_W-1:0]   r_shift;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_chk;
    logic [7:0]        r_seq;
    logic [15:0]       r_frames;

    logic              w_xfer;
    logic              w_pop;
    logic [7:0]        w_head;

    // Byte accepted by the sink; only possible while a frame is in flight
    assign w_xfer = o_out_valid && i_out_ready;
    // Pop only from IDLE; gating with reset keeps the strobe low during reset
    assign w_pop  = (r_state == StIdle) && i_en && i_evt_valid && !i_rst;
    assign w_head = r_shift[SR_W-1 -: 8];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: every non-idle state advances only on a handshake
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_pop) w_state_next = StSof;
            end
            StSof: begin
                if (w_xfer) w_state_next = StSeq;
            end
            StSeq: begin
                if (w_xfer) w_state_next = StPayload;
            end
            StPayload: begin
                if (w_xfer && (r_idx == LAST_IDX)) w_state_next = StChk;
            end
            StChk: begin
                if (w_xfer) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output decode: data depends only on registered state, so it holds during stalls
    always_comb begin
        o_out_valid = 1'b0;
        o_out_data  = 8'h00;
        o_out_last  = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_out_valid = 1'b0;
            end
            StSof: begin
                o_out_valid = 1'b1;
                o_out_data  = SOF_BYTE;
            end
            StSeq: begin
                o_out_valid = 1'b1;
                o_out_data  = r_seq;
            end
            StPayload: begin
                o_out_valid = 1'b1;
                o_out_data  = w_head;
            end
            StChk: begin
                o_out_valid = 1'b1;
                o_out_data  = r_chk;
                o_out_last  = 1'b1;
            end
            default: begin
                o_out_valid = 1'b0;
            end
        endcase
    end

    assign o_evt_pop     = w_pop;
    assign o_busy        = (r_state != StIdle);
    assign o_seq         = r_seq;
    assign o_frames_sent = r_frames;

    // Datapath: event shift register, byte index, checksum and frame counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift  <= '0;
            r_idx    <= '0;
            r_chk    <= 8'h00;
            r_seq    <= 8'h00;
            r_frames <= 16'h0000;
        end else begin
            if (w_pop) begin
                // Event sits zero-padded at the MSB end so the first byte out is the top byte
                r_shift <= SR_W'(i_evt_data);
                r_idx   <= '0;
                r_chk   <= 8'h00;
            end
            if (w_xfer) begin
                unique case (r_state)
                    StSeq: begin
                        r_chk <= r_seq;
                    end
                    StPayload: begin
                        r_chk   <= r_chk ^ w_head;
                        r_shift <= r_shift << 8;
                        r_idx   <= r_idx + 1'b1;
                    end
                    StChk: begin
                        r_seq    <= r_seq + 8'd1;
                        r_frames <= r_frames + 16'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_event_packetizer.sv
// Directed self-checking bench for event_packetizer.
module tb_event_packetizer;

    localparam int FRAME_LEN = 12;
    localparam logic [71:0] EV1  = {32'h0000_0005, 8'h3C, 32'hDEAD_BEEF};
    localparam logic [71:0] EV_B = {32'h0000_0100, 8'h01, 32'h1234_5678};
    localparam logic [71:0] EV_C = {32'hFFFF_FFFF, 8'hFF, 32'h0000_0000};

    logic        clk = 1'b0;
    logic        i_rst, i_en, i_evt_valid, i_out_ready;
    logic [71:0] i_evt_data;
    logic        o_evt_pop, o_out_valid, o_out_last, o_busy;
    logic [7:0]  o_out_data, o_seq;
    logic [15:0] o_frames_sent;

    logic [71:0] q[$];
    int          total = 0;
    int          bad = 0;
    int          pop_cnt = 0;
    int          proto_bad = 0;
    logic        prev_pop = 1'b0;
    logic [7:0]  cap_data[0:15];
    logic        cap_last[0:15];
    int          cap_n, cap_idle, cap_stall_bad;

    always #5 clk = ~clk;

    event_packetizer dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_evt_valid   (i_evt_valid),
        .i_evt_data    (i_evt_data),
        .o_evt_pop     (o_evt_pop),
        .o_out_valid   (o_out_valid),
        .o_out_data    (o_out_data),
        .o_out_last    (o_out_last),
        .i_out_ready   (i_out_ready),
        .o_busy        (o_busy),
        .o_seq         (o_seq),
        .o_frames_sent (o_frames_sent)
    );

    // Reference frame byte i for event ev sent with sequence number s
    function automatic logic [7:0] exp_byte(input logic [71:0] ev, input logic [7:0] s,
                                            input int i);
        logic [7:0] c;
        c = s;
        if (i == 0) return 8'hA5;
        if (i == 1) return s;
        if (i <= 10) return ev[71-8*(i-2) -: 8];
        for (int j = 0; j < 9; j++) c = c ^ ev[71-8*j -: 8];
        return c;
    endfunction

    task automatic drive_src();
        i_evt_valid = (q.size() > 0);
        i_evt_data  = (q.size() > 0) ? q[0] : 72'h0;
    endtask

    // One clock: record pop strobe, advance, update the FIFO model
    task automatic step();
        logic pop;
        #1;
        pop = o_evt_pop;
        if (pop) begin
            pop_cnt++;
            if (prev_pop || o_busy) proto_bad++;
        end
        prev_pop = pop;
        @(posedge clk);
        #1;
        if (pop && q.size() > 0) void'(q.pop_front());
        drive_src();
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    // Sink: collect up to one frame; mode 1 drives ready as 1,0,0 repeating
    task automatic recv(input int mode, input int en_drop_at, input int abort_at);
        int         guard;
        logic       have_stall;
        logic [7:0] sd;
        logic       sl;
        cap_n = 0;
        cap_idle = 0;
        cap_stall_bad = 0;
        guard = 0;
        have_stall = 1'b0;
        sd = 8'h00;
        sl = 1'b0;
        while (cap_n < FRAME_LEN && cap_n != abort_at && guard < 400) begin
            if (have_stall && (o_out_valid !== 1'b1 || o_out_data !== sd || o_out_last !== sl))
                cap_stall_bad++;
            have_stall = 1'b0;
            if (cap_n == en_drop_at) i_en = 1'b0;
            i_out_ready = (mode == 0) ? 1'b1 : ((guard % 3) == 0);
            if (o_out_valid !== 1'b1) begin
                if (cap_n == 0) cap_idle++;
            end else if (i_out_ready) begin
                cap_data[cap_n] = o_out_data;
                cap_last[cap_n] = o_out_last;
                cap_n++;
            end else begin
                have_stall = 1'b1;
                sd = o_out_data;
                sl = o_out_last;
            end
            guard++;
            step();
        end
        i_out_ready = 1'b1;
        total++;
        if (guard >= 400) begin
            bad++;
            $display("FAIL recv_timeout: got %0d bytes want %0d", cap_n, FRAME_LEN);
        end
    endtask

    task automatic test_reset();
        q.push_back(EV1);
        drive_src();
        i_rst = 1'b1;
        repeat (3) step();
        total++; if (o_evt_pop !== 1'b0) begin bad++; $display("FAIL rst_pop: got %b want 0", o_evt_pop); end
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", o_out_valid); end
        total++; if (o_out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", o_out_data); end
        total++; if (o_out_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", o_out_last); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        total++; if (o_seq !== 8'h00) begin bad++; $display("FAIL rst_seq: got %h want 00", o_seq); end
        total++; if (o_frames_sent !== 16'h0) begin bad++; $display("FAIL rst_frames: got %h want 0", o_frames_sent); end
        total++; if (pop_cnt !== 0) begin bad++; $display("FAIL rst_popcnt: got %0d want 0", pop_cnt); end
        q.delete();
        drive_src();
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [7:0] exp [0:11];
        int p0;
        exp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h3C,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h1B};
        p0 = pop_cnt;
        q.push_back(EV1);
        drive_src();
        recv(0, 99, 99);
        total++; if (cap_n !== FRAME_LEN) begin bad++; $display("FAIL single_len: got %0d want %0d", cap_n, FRAME_LEN); end
        for (int i = 0; i < FRAME_LEN; i++) begin
            total++;
            if (cap_data[i] !== exp[i]) begin
                bad++; $display("FAIL single_byte[%0d]: got %h want %h", i, cap_data[i], exp[i]);
            end
            total++;
            if (cap_last[i] !== (i == FRAME_LEN - 1)) begin
                bad++; $display("FAIL single_last[%0d]: got %b want %b", i, cap_last[i], i == FRAME_LEN - 1);
            end
        end
        total++; if (o_seq !== 8'h01) begin bad++; $display("FAIL single_seq: got %h want 01", o_seq); end
        total++; if (o_frames_sent !== 16'd1) begin bad++; $display("FAIL single_frames: got %0d want 1", o_frames_sent); end
        total++; if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL single_pops: got %0d want 1", pop_cnt - p0); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", o_busy); end
    endtask

    task automatic test_stall();
        q.push_back(EV1);
        drive_src();
        recv(1, 99, 99);
        total++; if (cap_n !== FRAME_LEN) begin bad++; $display("FAIL stall_len: got %0d want %0d", cap_n, FRAME_LEN); end
        for (int i = 0; i < FRAME_LEN; i++) begin
            total++;
            if (cap_data[i] !== exp_byte(EV1, 8'h01, i)) begin
                bad++; $display("FAIL stall_byte[%0d]: got %h want %h", i, cap_data[i], exp_byte(EV1, 8'h01, i));
            end
        end
        total++; if (cap_data[11] !== 8'h1A) begin bad++; $display("FAIL stall_chk: got %h want 1a", cap_data[11]); end
        total++; if (cap_stall_bad !== 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", cap_stall_bad); end
        total++; if (o_seq !== 8'h02) begin bad++; $display("FAIL stall_seq: got %h want 02", o_seq); end
    endtask

    task automatic test_back_to_back();
        logic [71:0] ev [0:2];
        int p0;
        ev = '{EV1, EV_B, EV_C};
        do_reset();
        p0 = pop_cnt;
        for (int f = 0; f < 3; f++) q.push_back(ev[f]);
        drive_src();
        for (int f = 0; f < 3; f++) begin
            recv(0, 99, 99);
            for (int i = 0; i < FRAME_LEN; i++) begin
                total++;
                if (cap_data[i] !== exp_byte(ev[f], 8'(f), i)) begin
                    bad++; $display("FAIL b2b_f%0d_byte[%0d]: got %h want %h", f, i, cap_data[i],
                                    exp_byte(ev[f], 8'(f), i));
                end
            end
            total++;
            if (cap_idle < 1) begin bad++; $display("FAIL b2b_gap_f%0d: got %0d idle want >=1", f, cap_idle); end
        end
        total++; if (pop_cnt - p0 !== 3) begin bad++; $display("FAIL b2b_pops: got %0d want 3", pop_cnt - p0); end
        total++; if (o_frames_sent !== 16'd3) begin bad++; $display("FAIL b2b_frames: got %0d want 3", o_frames_sent); end
        total++; if (proto_bad !== 0) begin bad++; $display("FAIL pop_protocol: got %0d bad pops want 0", proto_bad); end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        for (int n = 0; n < 255; n++) begin
            q.push_back(EV1);
            drive_src();
            recv(0, 99, 99);
        end
        total++; if (o_seq !== 8'hFF) begin bad++; $display("FAIL wrap_pre_seq: got %h want ff", o_seq); end
        q.push_back(EV1);
        drive_src();
        recv(0, 99, 99);
        total++; if (cap_data[1] !== 8'hFF) begin bad++; $display("FAIL wrap_seq_ff: got %h want ff", cap_data[1]); end
        total++; if (cap_data[11] !== 8'hE4) begin bad++; $display("FAIL wrap_chk_ff: got %h want e4", cap_data[11]); end
        total++; if (o_seq !== 8'h00) begin bad++; $display("FAIL wrap_seq_zero: got %h want 00", o_seq); end
        q.push_back(EV1);
        drive_src();
        recv(0, 99, 99);
        total++; if (cap_data[1] !== 8'h00) begin bad++; $display("FAIL wrap_seq_00: got %h want 00", cap_data[1]); end
        total++; if (o_frames_sent !== 16'd257) begin bad++; $display("FAIL wrap_frames: got %0d want 257", o_frames_sent); end
    endtask

    task automatic test_enable();
        int p0;
        logic [7:0] s0;
        i_en = 1'b0;
        q.push_back(EV1);
        drive_src();
        p0 = pop_cnt;
        repeat (5) step();
        total++; if (pop_cnt !== p0) begin bad++; $display("FAIL en_off_pops: got %0d want %0d", pop_cnt, p0); end
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL en_off_valid: got %b want 0", o_out_valid); end
        q.push_back(EV_B);
        drive_src();
        s0 = o_seq;
        i_en = 1'b1;
        recv(0, 3, 99);
        total++; if (cap_n !== FRAME_LEN) begin bad++; $display("FAIL en_drop_len: got %0d want %0d", cap_n, FRAME_LEN); end
        for (int i = 0; i < FRAME_LEN; i++) begin
            total++;
            if (cap_data[i] !== exp_byte(EV1, s0, i)) begin
                bad++; $display("FAIL en_drop_byte[%0d]: got %h want %h", i, cap_data[i], exp_byte(EV1, s0, i));
            end
        end
        repeat (10) step();
        total++; if (pop_cnt - p0 !== 1) begin bad++; $display("FAIL en_drop_pops: got %0d want 1", pop_cnt - p0); end
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL en_drop_valid: got %b want 0", o_out_valid); end
        q.delete();
        drive_src();
        i_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        q.push_back(EV_B);
        q.push_back(EV_C);
        drive_src();
        recv(0, 99, 5);
        total++; if (o_out_data !== 8'h00 || o_busy !== 1'b1) begin
            bad++; $display("FAIL mid_pre: got data=%h busy=%b want 00/1", o_out_data, o_busy);
        end
        i_rst = 1'b1;
        step();
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", o_out_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
        total++; if (o_seq !== 8'h00) begin bad++; $display("FAIL mid_rst_seq: got %h want 00", o_seq); end
        total++; if (o_out_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %h want 00", o_out_data); end
        i_rst = 1'b0;
        recv(0, 99, 99);
        for (int i = 0; i < FRAME_LEN; i++) begin
            total++;
            if (cap_data[i] !== exp_byte(EV_C, 8'h00, i)) begin
                bad++; $display("FAIL mid_fresh_byte[%0d]: got %h want %h", i, cap_data[i],
                                exp_byte(EV_C, 8'h00, i));
            end
        end
        total++; if (o_frames_sent !== 16'd1) begin bad++; $display("FAIL mid_frames: got %0d want 1", o_frames_sent); end
    endtask

    initial begin
        i_rst       = 1'b1;
        i_en        = 1'b1;
        i_out_ready = 1'b1;
        drive_src();
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_seq_wrap();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
